// File: rtl/dcache_types.sv
// dcache_types: shared types and constants for the L1 data-cache controller.
//   dcache_state_t : controller FSM states
//   DIN_*          : datain_sel encodings (data-array write source)
//   PADDR_*        : pmem_addr_sel encodings (physical address source)
package dcache_types;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    ALLOCATE   = 2'd2
  } dcache_state_t;

  localparam logic DIN_MESH  = 1'b0;  // merged store line from the mesh
  localparam logic DIN_PMEM  = 1'b1;  // line returned by physical memory

  localparam logic PADDR_CPU = 1'b0;  // CPU address (line fill)
  localparam logic PADDR_WB  = 1'b1;  // {victim tag, index, 4'b0} (write-back)

endpackage

// File: rtl/dcache_sat_counter.sv
// dcache_sat_counter: saturating up-counter used for cache performance stats.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset, clears count
//   inc   in   increment request for this cycle
//   count out  CNT_WIDTH-bit count, sticks at all-ones
module dcache_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dcache_control.sv
// dcache_control: control FSM for a 2-way set-associative, write-back,
// write-allocate L1 data cache with 16-byte lines. Decides hit/miss, picks
// the victim way and orders write-back and line fill; the datapath does all
// data movement.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_read, mem_write      CPU request levels (held until mem_resp)
//   mem_byte_enable[1:0]     store lane mask, 2'b00 = null store
//   hit0/1, valid0/1, dirty0/1, lru_out   per-way status of the indexed set
//   pmem_resp                physical memory finished the line transfer
//   mem_resp                 one-cycle CPU completion pulse
//   pmem_read, pmem_write    line fill / write-back request levels
//   pmem_addr_sel            0 = CPU address, 1 = victim write-back address
//   way_sel, load_data, datain_sel, load_tag, load_dirty, dirty_in,
//   load_lru, lru_in         array control for the datapath
//   hit_count, miss_count, wb_count   performance counters
//
// Optional feature: define DCACHE_PERF_CNT_EN to build the saturating
// performance counters; otherwise the counter outputs are tied to 0.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | serve hits with zero wait; on a miss latch victim way
// WRITE_BACK | write dirty victim line to pmem until pmem_resp
// ALLOCATE   | fill the victim way from pmem; load tag/data on pmem_resp
module dcache_control #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [1:0]           mem_byte_enable,
  input  logic                 hit0,
  input  logic                 hit1,
  input  logic                 valid0,
  input  logic                 valid1,
  input  logic                 dirty0,
  input  logic                 dirty1,
  input  logic                 lru_out,
  input  logic                 pmem_resp,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic                 pmem_addr_sel,
  output logic                 way_sel,
  output logic                 load_data,
  output logic                 datain_sel,
  output logic                 load_tag,
  output logic                 load_dirty,
  output logic                 dirty_in,
  output logic                 load_lru,
  output logic                 lru_in,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  import dcache_types::*;

  dcache_state_t state_q, state_d;
  logic          victim_q, victim_d;

  logic req;
  logic hit;
  logic hit_way;
  logic null_store;
  logic victim_needs_wb;

  // A simultaneous read+write is a store; on a double hit way 0 wins.
  assign req             = mem_read | mem_write;
  assign hit             = hit0 | hit1;
  assign hit_way         = ~hit0;
  assign null_store      = mem_write && (mem_byte_enable == 2'b00);
  assign victim_needs_wb = lru_out ? (valid1 & dirty1) : (valid0 & dirty0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    victim_d = victim_q;
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          victim_d = lru_out;
          state_d  = victim_needs_wb ? WRITE_BACK : ALLOCATE;
        end
      end
      WRITE_BACK: begin
        if (pmem_resp) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        if (pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = PADDR_CPU;
    way_sel       = 1'b0;
    load_data     = 1'b0;
    datain_sel    = DIN_MESH;
    load_tag      = 1'b0;
    load_dirty    = 1'b0;
    dirty_in      = 1'b0;
    load_lru      = 1'b0;
    lru_in        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && hit) begin
          mem_resp = 1'b1;
          // A null store completes without touching any array or the LRU.
          if (!null_store) begin
            way_sel  = hit_way;
            load_lru = 1'b1;
            lru_in   = ~hit_way;
            if (mem_write) begin
              load_data  = 1'b1;
              datain_sel = DIN_MESH;
              load_dirty = 1'b1;
              dirty_in   = 1'b1;
            end
          end
        end
      end
      WRITE_BACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = PADDR_WB;
        way_sel       = victim_q;
      end
      ALLOCATE: begin
        pmem_read     = 1'b1;
        pmem_addr_sel = PADDR_CPU;
        way_sel       = victim_q;
        if (pmem_resp) begin
          load_data  = 1'b1;
          datain_sel = DIN_PMEM;
          load_tag   = 1'b1;
          load_dirty = 1'b1;
          dirty_in   = 1'b0;
        end
      end
      default: ;
    endcase
  end

`ifdef DCACHE_PERF_CNT_EN
  logic hit_inc;
  logic miss_inc;
  logic wb_inc;

  assign hit_inc  = (state_q == IDLE) && req && hit;
  assign miss_inc = (state_q == IDLE) && req && !hit;
  assign wb_inc   = (state_q == WRITE_BACK) && pmem_resp;

  dcache_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_count)
  );

  dcache_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_count)
  );

  dcache_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wb_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (wb_inc),
    .count (wb_count)
  );
`else
  assign hit_count  = '0;
  assign miss_count = '0;
  assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_dcache_control.sv
// tb_dcache_control: directed, scoreboard-based bench for dcache_control.
// Each step drives the inputs just after a rising edge, queues the expected
// output vector, and compares it against the DUT on the following falling edge.
module tb_dcache_control;

  localparam int CW = 4;

`ifdef DCACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Bit positions of the packed output vector.
  localparam logic [11:0] R     = 12'h800;  // mem_resp
  localparam logic [11:0] PRD   = 12'h400;  // pmem_read
  localparam logic [11:0] PWR   = 12'h200;  // pmem_write
  localparam logic [11:0] ASEL  = 12'h100;  // pmem_addr_sel
  localparam logic [11:0] WAY   = 12'h080;  // way_sel
  localparam logic [11:0] LD    = 12'h040;  // load_data
  localparam logic [11:0] DSEL  = 12'h020;  // datain_sel
  localparam logic [11:0] LTAG  = 12'h010;  // load_tag
  localparam logic [11:0] LDRT  = 12'h008;  // load_dirty
  localparam logic [11:0] DIN   = 12'h004;  // dirty_in
  localparam logic [11:0] LLRU  = 12'h002;  // load_lru
  localparam logic [11:0] LRUIN = 12'h001;  // lru_in

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_read, mem_write;
  logic [1:0]    mem_byte_enable;
  logic          hit0, hit1, valid0, valid1, dirty0, dirty1, lru_out, pmem_resp;
  logic          mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel;
  logic          load_data, datain_sel, load_tag, load_dirty, dirty_in, load_lru, lru_in;
  logic [CW-1:0] hit_count, miss_count, wb_count;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  dcache_control #(.CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .hit0            (hit0),
    .hit1            (hit1),
    .valid0          (valid0),
    .valid1          (valid1),
    .dirty0          (dirty0),
    .dirty1          (dirty1),
    .lru_out         (lru_out),
    .pmem_resp       (pmem_resp),
    .mem_resp        (mem_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_addr_sel   (pmem_addr_sel),
    .way_sel         (way_sel),
    .load_data       (load_data),
    .datain_sel      (datain_sel),
    .load_tag        (load_tag),
    .load_dirty      (load_dirty),
    .dirty_in        (dirty_in),
    .load_lru        (load_lru),
    .lru_in          (lru_in),
    .hit_count       (hit_count),
    .miss_count      (miss_count),
    .wb_count        (wb_count)
  );

  wire [11:0] obs = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel,
                     load_data, datain_sel, load_tag, load_dirty, dirty_in,
                     load_lru, lru_in};

  task automatic drive(input logic rd, input logic wr, input logic [1:0] be,
                       input logic h0, input logic h1, input logic v0, input logic v1,
                       input logic d0, input logic d1, input logic lr, input logic pr);
    mem_read = rd; mem_write = wr; mem_byte_enable = be;
    hit0 = h0; hit1 = h1; valid0 = v0; valid1 = v1;
    dirty0 = d0; dirty1 = d1; lru_out = lr; pmem_resp = pr;
  endtask

  // Compare the queued expectation at the falling edge (no edge advance).
  task automatic sample(input string tag, input logic [11:0] expv);
    logic [11:0] e;
    exp_q.push_back(expv);
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    assert (obs === e) passed++;
    else begin
      fails++;
      $error("FAIL %s: outputs got %03h expected %03h", tag, obs, e);
    end
  endtask

  task automatic check_cnt(input string tag, input int eh, input int em, input int ew);
    total++;
    assert (hit_count === CW'(eh)) passed++;
    else begin fails++; $error("FAIL %s hit_count: got %0d expected %0d", tag, hit_count, eh); end
    total++;
    assert (miss_count === CW'(em)) passed++;
    else begin fails++; $error("FAIL %s miss_count: got %0d expected %0d", tag, miss_count, em); end
    total++;
    assert (wb_count === CW'(ew)) passed++;
    else begin fails++; $error("FAIL %s wb_count: got %0d expected %0d", tag, wb_count, ew); end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [11:0] expv);
    sample(tag, expv);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state: idle, nothing requested.
    sample("reset_idle", 12'h000);
    check_cnt("reset", 0, 0, 0);
    next_cycle();

    // Load hit on way 1.
    drive(1, 0, 2'b00, 0, 1, 1, 1, 0, 0, 1, 0);
    step("load_hit1", R | WAY | LLRU);

    // Store hit on way 0.
    drive(0, 1, 2'b01, 1, 0, 1, 1, 0, 0, 0, 0);
    step("store_hit0", R | LD | LDRT | DIN | LLRU | LRUIN);

    // Null store: response only.
    drive(0, 1, 2'b00, 1, 0, 1, 1, 0, 0, 0, 0);
    step("null_store", R);

    // Read and write together is a store.
    drive(1, 1, 2'b10, 0, 1, 1, 1, 0, 0, 0, 0);
    step("rdwr_store1", R | WAY | LD | LDRT | DIN | LLRU);

    // Double hit: way 0 wins.
    drive(1, 0, 2'b00, 1, 1, 1, 1, 0, 0, 1, 0);
    step("double_hit", R | LLRU | LRUIN);

    // Spurious pmem_resp in IDLE, then confirm still IDLE with a hit.
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
    step("idle_presp", 12'h000);
    drive(1, 0, 2'b00, 0, 1, 1, 1, 0, 0, 0, 0);
    step("idle_after_presp", R | WAY | LLRU);

    // Dirty miss on way 0: write-back 6 cycles, fill 5 cycles, then hit.
    drive(1, 0, 2'b00, 0, 0, 1, 0, 1, 0, 0, 0);
    step("dmiss_idle", 12'h000);
    for (int i = 1; i <= 6; i++) begin
      drive(1, 0, 2'b00, 0, 0, 1, 0, 1, 0, 0, logic'(i == 6));
      step("dmiss_wb", PWR | ASEL);
    end
    for (int i = 1; i <= 5; i++) begin
      drive(1, 0, 2'b00, 0, 0, 1, 0, 1, 0, 0, logic'(i == 5));
      step("dmiss_alloc", (i == 5) ? (PRD | LD | DSEL | LTAG | LDRT) : PRD);
    end
    drive(1, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0);
    step("dmiss_hit", R | LLRU | LRUIN);

    // Clean miss with victim 1; LRU and way-0 status flip during the fill.
    drive(1, 0, 2'b00, 0, 0, 0, 1, 0, 0, 1, 0);
    step("cmiss_idle", 12'h000);
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 2'b00, 0, 0, 1, 1, 1, 1, 0, logic'(i == 3));
      step("cmiss_alloc", (i == 3) ? (PRD | WAY | LD | DSEL | LTAG | LDRT) : (PRD | WAY));
    end
    drive(1, 0, 2'b00, 0, 1, 1, 1, 1, 1, 0, 0);
    step("cmiss_hit", R | WAY | LLRU);

    // Request dropped mid-miss: sequence completes, no mem_resp.
    drive(0, 1, 2'b01, 0, 0, 0, 1, 0, 1, 1, 0);
    step("drop_idle", 12'h000);
    drive(0, 0, 2'b00, 0, 0, 0, 1, 0, 1, 1, 1);
    step("drop_wb", PWR | ASEL | WAY);
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
    step("drop_alloc", PRD | WAY | LD | DSEL | LTAG | LDRT);
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    step("drop_after", 12'h000);

    // Reset in the 3rd ALLOCATE cycle abandons the fill.
    drive(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rmiss_idle", 12'h000);
    step("rmiss_alloc1", PRD);
    step("rmiss_alloc2", PRD);
    rst = 1'b1;
    step("rmiss_alloc3_rst", PRD);
    rst = 1'b0;
    drive(1, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0);
    sample("rst_then_hit", R | LLRU | LRUIN);
    check_cnt("after_rst", 0, 0, 0);
    next_cycle();

    // 19 more hits (20 total since reset): hit_count saturates at 15.
    for (int i = 0; i < 19; i++) begin
      step("perf_hit", R | LLRU | LRUIN);
    end

    // One dirty miss with a one-cycle write-back and fill.
    drive(1, 0, 2'b00, 0, 0, 1, 0, 1, 0, 0, 0);
    step("pmiss_idle", 12'h000);
    drive(1, 0, 2'b00, 0, 0, 1, 0, 1, 0, 0, 1);
    step("pmiss_wb", PWR | ASEL);
    step("pmiss_alloc", PRD | LD | DSEL | LTAG | LDRT);
    drive(1, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0);
    sample("pmiss_hit", R | LLRU | LRUIN);
    check_cnt("perf", PERF ? 15 : 0, PERF ? 1 : 0, PERF ? 1 : 0);
    next_cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
